spd_mul_256: RTL and testbench
==============================

Name: spd_mul_256

Overview:
- Iterative 256x256 unsigned multiplier.
- Produces the 512-bit product that feeds the SM2 fast modular reducer through that block's p512_a / mod_vld_i input.
- It is the writer side of that interface:
  - its level-valid output produces exactly one rising edge per result;
  - it holds the product stable for as long as the reducer samples it.
- Operands are split into limbs, and one limb-by-limb partial product is accumulated per cycle.

Parameters:
- LIMB_W, 64, limb width in bits. Supported values are 32 and 64; 256 must be divisible by LIMB_W.
- N_LIMB, 256/LIMB_W, derived limb count. Not overridable.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- mul_start_i  input  1  single-cycle start request; accepted only in IDLE or DONE
- p256_a_i  input  256  operand A, sampled only on an accepted start
- p256_b_i  input  256  operand B, sampled only on an accepted start
- busy_o  output  1  high while state is MUL
- prod_vld_o  output  1  level valid, connected to the reducer's mod_vld_i
- p512_prod_o  output  512  product A*B, connected to the reducer's p512_a

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, cnt=0, operand registers=0, accumulator=0;
  - busy_o=0, prod_vld_o=0, p512_prod_o=0;
  - any operation in flight is abandoned; no partial valid is produced.
- States: IDLE, MUL, DONE.
- IDLE:
  - mul_start_i=1 at an edge latches A and B, clears the accumulator, sets cnt=0 and goes to MUL.
- MUL:
  - Each edge: acc <= acc + (a_limb[i] * b_limb[j]) << (LIMB_W*(i+j)), with i=cnt/N_LIMB and j=cnt%N_LIMB; then cnt <= cnt+1.
  - On the edge where cnt==N_LIMB*N_LIMB-1, the last partial product is added, state goes to DONE and prod_vld_o <= 1.
  - mul_start_i is ignored while in MUL: no queueing and no error flag.
- DONE:
  - prod_vld_o stays 1 and p512_prod_o stays stable until the next accepted start.
  - mul_start_i=1 accepts new operands exactly as in IDLE and clears prod_vld_o at the same edge.
  - This guarantees at least one low cycle between results, so the reducer sees a fresh rising edge.
- Latency:
  - prod_vld_o rises at the (N_LIMB^2+1)th edge after mul_start_i is sampled, counting the start edge as edge 1.
  - That is 17 edges with LIMB_W=64 and 65 edges with LIMB_W=32.
  - busy_o is high for exactly N_LIMB^2 cycles.
- Arithmetic:
  - Accumulator is 512 bits. The product of two 256-bit values never exceeds 2^512-2^257+1, so no carry-out exists.
  - Partial product is 2*LIMB_W bits, zero-extended to 512 before the shift.
  - Only one LIMB_W x LIMB_W multiplier is instantiated.
- p512_prod_o is driven directly from the accumulator:
  - it changes while busy_o=1;
  - it is meaningful only while prod_vld_o=1.
- Range contract:
  - The multiplier is exact for any 256-bit operands.
  - The caller is responsible for keeping A and B below p256, so the product stays below p^2 as the reducer requires.
- Simultaneous events: mul_start_i during the final MUL cycle is ignored; the result still completes normally.

Decomposition:
- Shared package sm2_pkg:
  - P256 constant;
  - width constants (256, 512);
  - state encoding localparams for IDLE/MUL/DONE.
- One natural sub-module: spd_mul_limb. It is a registered-free LIMB_W x LIMB_W unsigned multiplier, isolated so a DSP-mapped or pipelined version can be swapped in later.
- The top module spd_mul_256 holds the FSM, counter, operand registers and accumulator.

Test Plan:
- A=0, B=0xFFFF...FF, start -> prod_vld_o rises 17 edges later and p512_prod_o=0; busy_o high for 16 cycles.
- A=B=2^256-1 -> p512_prod_o = 0xFFFF...FFFE (256 bits) followed by 0x0000...0001 (256 bits), i.e. 2^512-2^257+1.
- A=B=P256-1, output chained into the reducer -> reducer p256_b=1 and reducer fin pulse 3 cycles after prod_vld_o rises.
- Start with A=1, B=P256; during MUL, pulse start with A=B=5 -> second start ignored, result=P256, busy_o waveform unchanged.
- From DONE, start A=2, B=3 -> prod_vld_o falls at the accepting edge, rises 17 edges later, and the result is 6; the reducer fires exactly once per result.
- Assert rst_n=0 at cnt=7 -> all outputs 0 immediately, state IDLE; a subsequent start A=7, B=9 completes with product 63 and no stale accumulation.

Source files
------------

// File: rtl/sm2_pkg.sv
// Shared SM2 constants: the curve prime, datapath widths and the multiplier FSM encoding.
package sm2_pkg;

   localparam int W256 = 256;
   localparam int W512 = 512;

   localparam logic [W256-1:0] P256 =
      256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/spd_mul_limb.sv
// Combinational LIMB_W x LIMB_W unsigned multiplier, kept separate so a DSP or pipelined version can replace it.
module spd_mul_limb #(
   parameter int LIMB_W = 64
) (
   input  logic [LIMB_W-1:0]   a,
   input  logic [LIMB_W-1:0]   b,
   output logic [2*LIMB_W-1:0] p
);

   assign p = {{LIMB_W{1'b0}}, a} * {{LIMB_W{1'b0}}, b};

endmodule

// File: rtl/spd_mul_256.sv
// Iterative 256x256 multiplier: one limb partial product per cycle into a 512-bit accumulator,
// presented to the reducer as a level-valid product that stays stable until the next start.
module spd_mul_256
   import sm2_pkg::*;
#(
   parameter int LIMB_W = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mul_start_i,
   input  logic [W256-1:0] p256_a_i,
   input  logic [W256-1:0] p256_b_i,
   output logic            busy_o,
   output logic            prod_vld_o,
   output logic [W512-1:0] p512_prod_o
);

   localparam int N_LIMB = W256 / LIMB_W;
   localparam int IDX_W  = $clog2(N_LIMB);
   localparam int CNT_W  = 2 * IDX_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_LIMB * N_LIMB - 1);

   logic [1:0]            state;
   logic [CNT_W-1:0]      cnt;
   logic [W256-1:0]       op_a;
   logic [W256-1:0]       op_b;
   logic [W512-1:0]       acc;
   logic                  vld;

   logic [LIMB_W-1:0]     a_limbs [N_LIMB];
   logic [LIMB_W-1:0]     b_limbs [N_LIMB];
   logic [IDX_W-1:0]      i_idx;
   logic [IDX_W-1:0]      j_idx;
   logic [IDX_W:0]        sum_idx;
   logic [9:0]            shamt;
   logic [2*LIMB_W-1:0]   pp;
   logic [W512-1:0]       pp_shift;

   always_comb begin
      for (int k = 0; k < N_LIMB; k++) begin
         a_limbs[k] = op_a[k*LIMB_W +: LIMB_W];
         b_limbs[k] = op_b[k*LIMB_W +: LIMB_W];
      end
   end

   // cnt walks i in the upper half and j in the lower half, since N_LIMB is a power of two
   assign i_idx   = cnt[CNT_W-1:IDX_W];
   assign j_idx   = cnt[IDX_W-1:0];
   assign sum_idx = {1'b0, i_idx} + {1'b0, j_idx};
   assign shamt   = 10'(sum_idx) * 10'(LIMB_W);

   spd_mul_limb #(.LIMB_W(LIMB_W)) u_limb (
      .a (a_limbs[i_idx]),
      .b (b_limbs[j_idx]),
      .p (pp)
   );

   assign pp_shift = {{(W512-2*LIMB_W){1'b0}}, pp} << shamt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         op_a  <= '0;
         op_b  <= '0;
         acc   <= '0;
         vld   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               // Dropping vld on the accepting edge guarantees the reducer a fresh rising edge per result
               if (mul_start_i) begin
                  op_a  <= p256_a_i;
                  op_b  <= p256_b_i;
                  acc   <= '0;
                  cnt   <= '0;
                  vld   <= 1'b0;
                  state <= ST_MUL;
               end
            end
            ST_MUL: begin
               acc <= acc + pp_shift;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= ST_DONE;
                  vld   <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy_o      = (state == ST_MUL);
   assign prod_vld_o  = vld;
   assign p512_prod_o = acc;

endmodule

// File: tb/tb_spd_mul_256.sv
// Directed bench for spd_mul_256: a timeline model of the multiplier checked every cycle, plus literal result pins.
module tb_spd_mul_256;
   import sm2_pkg::*;

   localparam int LIMB_W  = 64;
   localparam int N_SQ    = (256 / LIMB_W) * (256 / LIMB_W);
   localparam int EXP_LAT = N_SQ + 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            mul_start = 1'b0;
   logic [255:0]    a_in = '0;
   logic [255:0]    b_in = '0;
   logic            busy;
   logic            prod_vld;
   logic [511:0]    prod;

   int checkCount = 0;
   int errorCount = 0;
   int vldRises   = 0;

   // Timeline model: a start seen while not busy triggers N_SQ busy cycles, then the product is valid
   int           mBusyLeft;
   logic         mVld;
   logic [511:0] mProd;

   spd_mul_256 #(.LIMB_W(LIMB_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mul_start_i (mul_start),
      .p256_a_i    (a_in),
      .p256_b_i    (b_in),
      .busy_o      (busy),
      .prod_vld_o  (prod_vld),
      .p512_prod_o (prod)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mBusyLeft = 0;
         mVld      = 1'b0;
         mProd     = '0;
      end else if (mBusyLeft > 0) begin
         mBusyLeft = mBusyLeft - 1;
         if (mBusyLeft == 0) mVld = 1'b1;
      end else if (mul_start) begin
         mBusyLeft = N_SQ;
         mVld      = 1'b0;
         mProd     = {256'b0, a_in} * {256'b0, b_in};
      end
   end

   always @(posedge prod_vld) vldRises++;

   task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         #1;
         checkOutput("busy_cycle", 512'(busy), 512'(mBusyLeft > 0));
         checkOutput("vld_cycle", 512'(prod_vld), 512'(mVld));
         if (mVld) checkOutput("prod_cycle", prod, mProd);
      end
   end

   task automatic applyStimulus(input logic [255:0] a, input logic [255:0] b);
      @(negedge clk);
      a_in      = a;
      b_in      = b;
      mul_start = 1'b1;
      @(negedge clk);
      mul_start = 1'b0;
   endtask

   // Runs one multiply; optionally pulses a second start (A=B=5) once `pulseAt` edges have passed
   task automatic runOp(input string name, input logic [255:0] a, input logic [255:0] b,
                        input logic [511:0] expProd, input int pulseAt);
      int edges;
      int busyCycles;
      bit done;
      applyStimulus(a, b);
      #1;
      checkOutput({name, "_vld_low_after_start"}, 512'(prod_vld), 512'(0));
      edges      = 1;
      busyCycles = 0;
      done       = 1'b0;
      while (!done && edges < 200) begin
         if (busy) busyCycles++;
         if (prod_vld) done = 1'b1;
         else begin
            @(negedge clk);
            edges++;
            mul_start = 1'b0;
            if (edges == pulseAt) begin
               a_in      = 256'd5;
               b_in      = 256'd5;
               mul_start = 1'b1;
            end
            #1;
         end
      end
      mul_start = 1'b0;
      checkOutput({name, "_done"}, 512'(done), 512'(1));
      checkOutput({name, "_latency"}, 512'(edges), 512'(EXP_LAT));
      checkOutput({name, "_busy_cycles"}, 512'(busyCycles), 512'(N_SQ));
      checkOutput({name, "_prod"}, prod, expProd);
   endtask

   initial begin
      int rises;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_busy", 512'(busy), 512'(0));
      checkOutput("reset_vld", 512'(prod_vld), 512'(0));
      checkOutput("reset_prod", prod, 512'(0));
      @(negedge clk);
      rst_n = 1'b1;

      runOp("zero_a", 256'd0, {256{1'b1}}, 512'(0), -1);
      runOp("all_ones", {256{1'b1}}, {256{1'b1}},
            {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1}, -1);
      runOp("p_minus_1_sq", P256 - 256'd1, P256 - 256'd1,
            {256'b0, P256 - 256'd1} * {256'b0, P256 - 256'd1}, -1);
      runOp("start_mid_mul", 256'd1, P256, {256'b0, P256}, 5);
      runOp("start_last_cycle", 256'd1, P256, {256'b0, P256}, EXP_LAT - 1);

      rises = vldRises;
      runOp("from_done", 256'd2, 256'd3, 512'd6, -1);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("vld_single_rise", 512'(vldRises - rises), 512'(1));
      checkOutput("vld_held", 512'(prod_vld), 512'(1));
      checkOutput("prod_held", prod, 512'd6);

      // Abort mid-operation once cnt has reached 7
      applyStimulus({256{1'b1}}, {256{1'b1}});
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", 512'(busy), 512'(0));
      checkOutput("midreset_vld", 512'(prod_vld), 512'(0));
      checkOutput("midreset_prod", prod, 512'(0));
      @(negedge clk);
      rst_n = 1'b1;
      rises = vldRises;
      runOp("after_reset", 256'd7, 256'd9, 512'd63, -1);
      checkOutput("after_reset_rises", 512'(vldRises - rises), 512'(1));

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
